multi_length_packer: RTL and testbench
======================================

Name: multi_length_packer

Overview:
- Parametrised successor to the chain-configurable packer in the tracing datapath. Packs input vectors of any per-chain length L (1..N lanes) into dense N-lane output words.
- No overflow fallback: vectors are split across output-word boundaries, so packing is perfect.
- Adds valid/ready backpressure, an explicit flush that emits partial words with a fill count, and an asynchronous active-low reset.
- Sits between the vector reduction stages and the trace buffer.

Parameters:
- N, 8, lanes per input/output vector.
- DATA_WIDTH, 32, bits per lane.
- MAX_CHAINS, 4, number of chain contexts selected by chainId_in.
- PERSONAL_CONFIG_ID, 0, configId value that addresses this block.
- INITIAL_LENGTH, '{MAX_CHAINS{N}}, reset per-chain vector length. 0 = chain disabled; values >N are treated as disabled.
- INITIAL_COND, '{MAX_CHAINS{0}}, reset per-chain condition mask.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tracing  in  1  1 = packing mode, 0 = configuration mode.
- valid_in  in  1  vector_in valid.
- ready_out  out  1  block can accept vector_in this cycle.
- eof_in  in  2  end-of-frame flags (bit0 inner, bit1 outer).
- bof_in  in  2  beginning-of-frame flags.
- chainId_in  in  $clog2(MAX_CHAINS)  selects the chain context.
- flush_in  in  1  emit any partially filled word.
- configId  in  8  configuration target id.
- configData  in  8  configuration byte.
- vector_in  in  N x DATA_WIDTH  input lanes; lanes 0..L-1 are meaningful.
- vector_out  out  N x DATA_WIDTH  packed word; lane 0 holds the oldest element.
- fill_out  out  $clog2(N+1)  number of valid lanes in vector_out (N, except on a flush word).
- valid_out  out  1  vector_out valid.
- ready_in  in  1  downstream accepts vector_out.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - valid_out=0, vector_out=0, fill_out=0.
  - Accumulator contents=0, count=0, flush_pending=0, byte_counter=0.
  - Length and condition tables load their INITIAL_* values.
- Storage:
  - Accumulator: N lanes plus count in 0..N-1.
  - One output register (valid_out, vector_out, fill_out).
- Handshake:
  - ready_out = tracing & !flush_pending & (!valid_out | ready_in).
  - The output holds stable while valid_out & !ready_in.
  - valid_out drops the cycle after acceptance unless a new word is produced in the same cycle.
- Accept condition: valid_in & ready_out & L!=0 & cond_valid.
  - Vectors with L=0 or a failing condition are consumed with no state change.
- cond_valid:
  - 1 when the chain's mask is 0.
  - Otherwise 1 if any set mask bit matches: bit0 eof[0]=1, bit1 eof[0]=0, bit2 bof[0]=1, bit3 bof[0]=0, bit4 eof[1]=1, bit5 eof[1]=0, bit6 bof[1]=1, bit7 bof[1]=0.
- Packing on accept (t = count + L, range 1..2N-1):
  - Lanes 0..L-1 of vector_in go to positions count..t-1 of a 2N-lane concatenation.
  - If t<N: accumulator updated, count=t, no output.
  - If t>=N: positions 0..N-1 are registered to vector_out with fill_out=N and valid_out=1. Positions N..t-1 shift to accumulator lanes 0..t-N-1; count=t-N; vacated lanes are zeroed.
  - Latency: one cycle from the completing accept to valid_out.
- Flush (sampled when tracing=1 and the output register is free, i.e. !valid_out | ready_in):
  - count=0 with no accept: no-op.
  - Otherwise the partial word is emitted with fill_out=count, lanes >=count zero, and count=0.
- Flush in the same cycle as an accept: the accept is applied first.
  - t<=N: one word is emitted with fill_out=t.
  - t>N: the full word is emitted now, flush_pending=1, ready_out=0. Next free cycle the remainder is emitted with fill_out=t-N; then flush_pending=0.
- Flush while the output is stalled: ignored. The requester holds flush_in until it is accepted (flush taken when ready_out would be 1 or count=0).
- Configuration mode (tracing=0):
  - No accepts. A pending output still drains.
  - If configId==PERSONAL_CONFIG_ID: byte_counter increments each cycle. Bytes 0..MAX_CHAINS-1 write cond[byte_counter]. Bytes MAX_CHAINS..2*MAX_CHAINS-1 write length[byte_counter-MAX_CHAINS]. Later bytes are ignored; byte_counter saturates at 255.
  - Else byte_counter=0.
  - Accumulator contents are preserved across configuration.
- Chain switching mid-word is allowed. Elements of different chains are packed in arrival order.

Decomposition:
- Package multi_length_packer_pkg:
  - cond bit index constants (COND_EOF0 .. COND_NBOF1).
  - LEN_DISABLED=0.
  - Function cond_match(mask, eof, bof).
- One natural sub-module: packer_config_regs. It holds the byte_counter and the length/cond tables, and outputs the selected length and cond_valid.
- Shifter/merge logic stays in the top level.

Test Plan:
- N=8, L=8 on chain 0, 3 vectors, ready_in=1 → 3 words, each fill_out=8, one cycle after each accept.
- L=3, vectors A0-2, B0-2, C0-2 → one word A0..A2,B0..B2,C0,C1 (fill 8); count=1 holding C2.
- L=5, accumulator at count=6, flush_in with the accept → word fill 8, then next cycle a word of 3 lanes with lanes 3..7 zero; ready_out low for that one cycle.
- ready_in=0 for 4 cycles with a word pending → vector_out stable, ready_out=0, no input lost; all data intact after release.
- Config stream at configId=0: bytes 0x01,0,0,0,2,8,8,8 → chain 0 L=2 and packs only when eof_in[0]=1; vectors with eof_in[0]=0 are dropped.
- rst_n asserted mid-word (count=5, valid_out=1) → next edge sees valid_out=0, count=0; first post-reset word contains only post-reset data.

Source files
------------

// File: rtl/multi_length_packer_pkg.sv
// Shared constants and helpers for the multi-length packer: condition-mask bit
// positions, the disabled-length marker and the per-vector condition test.
package multi_length_packer_pkg;

  localparam int COND_EOF0  = 0;
  localparam int COND_NEOF0 = 1;
  localparam int COND_BOF0  = 2;
  localparam int COND_NBOF0 = 3;
  localparam int COND_EOF1  = 4;
  localparam int COND_NEOF1 = 5;
  localparam int COND_BOF1  = 6;
  localparam int COND_NBOF1 = 7;

  localparam logic [7:0] LEN_DISABLED = 8'd0;

  // An empty mask always passes; otherwise any one set bit whose frame-flag
  // condition holds lets the vector through.
  function automatic logic cond_match(input logic [7:0] mask,
                                      input logic [1:0] eof,
                                      input logic [1:0] bof);
    logic [7:0] hits;
    hits             = '0;
    hits[COND_EOF0]  = eof[0];
    hits[COND_NEOF0] = ~eof[0];
    hits[COND_BOF0]  = bof[0];
    hits[COND_NBOF0] = ~bof[0];
    hits[COND_EOF1]  = eof[1];
    hits[COND_NEOF1] = ~eof[1];
    hits[COND_BOF1]  = bof[1];
    hits[COND_NBOF1] = ~bof[1];
    return (mask == 8'h00) || ((mask & hits) != 8'h00);
  endfunction

endpackage

// File: rtl/packer_config_regs.sv
// Per-chain length and condition tables, loaded byte-serially while not tracing;
// presents the selected chain's effective length and condition result.
module packer_config_regs
  import multi_length_packer_pkg::*;
#(
  parameter int N                  = 8,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_LENGTH = {MAX_CHAINS{8'(N)}},
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_COND   = '0,
  parameter int LW                 = $clog2(N+1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tracing,
  input  logic [7:0]                    config_id,
  input  logic [7:0]                    config_data,
  input  logic [$clog2(MAX_CHAINS)-1:0] chain_id,
  input  logic [1:0]                    eof,
  input  logic [1:0]                    bof,
  output logic [LW-1:0]                 length,
  output logic                          cond_valid
);

  localparam int         CHW    = $clog2(MAX_CHAINS);
  localparam logic [7:0] MC8    = 8'(MAX_CHAINS);
  localparam logic [7:0] MC8X2  = 8'(2 * MAX_CHAINS);
  localparam logic [7:0] N8     = 8'(N);
  localparam logic [7:0] ID8    = 8'(PERSONAL_CONFIG_ID);

  logic [7:0]                   byte_counter;
  logic [MAX_CHAINS-1:0][7:0]   len_tab;
  logic [MAX_CHAINS-1:0][7:0]   cond_tab;
  logic [7:0]                   len_idx;
  logic [7:0]                   sel_len;

  assign len_idx = byte_counter - MC8;

  // NOTE: the tables are plain flops, not a RAM, so they take their reset
  // values asynchronously like any other state; a RAM-mapped table could not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_counter <= '0;
      len_tab      <= INITIAL_LENGTH;
      cond_tab     <= INITIAL_COND;
    end else if (!tracing && config_id == ID8) begin
      if (byte_counter < MC8) begin
        cond_tab[byte_counter[CHW-1:0]] <= config_data;
      end else if (byte_counter < MC8X2) begin
        len_tab[len_idx[CHW-1:0]] <= config_data;
      end
      if (byte_counter != 8'hFF) begin
        byte_counter <= byte_counter + 8'd1;
      end
    end else begin
      byte_counter <= '0;
    end
  end

  // Lengths above N cannot be packed, so they behave exactly like a disabled chain.
  assign sel_len    = len_tab[chain_id];
  assign length     = (sel_len == LEN_DISABLED || sel_len > N8) ? '0 : sel_len[LW-1:0];
  assign cond_valid = cond_match(cond_tab[chain_id], eof, bof);

endmodule

// File: rtl/multi_length_packer.sv
// Packs per-chain vectors of 1..N lanes into dense N-lane words, splitting
// vectors across word boundaries, with valid/ready handshakes and flush.
module multi_length_packer
  import multi_length_packer_pkg::*;
#(
  parameter int N                  = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int MAX_CHAINS         = 4,
  parameter int PERSONAL_CONFIG_ID = 0,
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_LENGTH = {MAX_CHAINS{8'(N)}},
  parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_COND   = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          tracing,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic [1:0]                    eof_in,
  input  logic [1:0]                    bof_in,
  input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
  input  logic                          flush_in,
  input  logic [7:0]                    configId,
  input  logic [7:0]                    configData,
  input  logic [N-1:0][DATA_WIDTH-1:0]  vector_in,
  output logic [N-1:0][DATA_WIDTH-1:0]  vector_out,
  output logic [$clog2(N+1)-1:0]        fill_out,
  output logic                          valid_out,
  input  logic                          ready_in
);

  localparam int LW = $clog2(N+1);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(2 * N);
  localparam logic [TW-1:0] N_T       = TW'(N);
  localparam logic [LW-1:0] FILL_FULL = LW'(N);

  typedef logic [N-1:0][DATA_WIDTH-1:0]   word_t;
  typedef logic [2*N-1:0][DATA_WIDTH-1:0] wide_t;

  logic [LW-1:0] length;
  logic          cond_valid;

  word_t         acc, acc_n;
  logic [CW-1:0] count, count_n;
  logic          flush_pending, flush_pending_n;
  logic          valid_n;
  word_t         vector_n;
  logic [LW-1:0] fill_n;

  logic          out_free;
  logic          accept;
  logic          flush_req;
  logic [TW-1:0] t;
  logic [TW-1:0] pos;
  wide_t         wide;

  packer_config_regs #(
    .N                  (N),
    .MAX_CHAINS         (MAX_CHAINS),
    .PERSONAL_CONFIG_ID (PERSONAL_CONFIG_ID),
    .INITIAL_LENGTH     (INITIAL_LENGTH),
    .INITIAL_COND       (INITIAL_COND),
    .LW                 (LW)
  ) u_config_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .tracing     (tracing),
    .config_id   (configId),
    .config_data (configData),
    .chain_id    (chainId_in),
    .eof         (eof_in),
    .bof         (bof_in),
    .length      (length),
    .cond_valid  (cond_valid)
  );

  assign out_free  = !valid_out || ready_in;
  assign ready_out = tracing && !flush_pending && out_free;
  assign accept    = valid_in && ready_out && (length != '0) && cond_valid;
  assign flush_req = tracing && flush_in;
  assign t         = TW'(count) + (accept ? TW'(length) : '0);

  // Incoming lanes land right after the current fill level in a 2N-lane view;
  // accumulator lanes at or above count are always zero, so no masking is needed.
  always_comb begin
    wide         = '0;
    wide[N-1:0]  = acc;
    pos          = '0;
    if (accept) begin
      for (int j = 0; j < N; j++) begin
        pos = TW'(count) + TW'(j);
        if (LW'(j) < length) begin
          wide[pos] = vector_in[j];
        end
      end
    end
  end

  // NOTE: every variable gets its hold value before any branch, so paths that
  // do not touch it cannot infer a latch.
  always_comb begin
    acc_n           = acc;
    count_n         = count;
    flush_pending_n = flush_pending;
    valid_n         = valid_out;
    vector_n        = vector_out;
    fill_n          = fill_out;
    if (out_free) begin
      valid_n = 1'b0;
      if (flush_pending) begin
        valid_n         = 1'b1;
        vector_n        = acc;
        fill_n          = LW'(count);
        acc_n           = '0;
        count_n         = '0;
        flush_pending_n = 1'b0;
      end else if (t >= N_T) begin
        valid_n         = 1'b1;
        vector_n        = wide[N-1:0];
        fill_n          = FILL_FULL;
        acc_n           = wide[2*N-1:N];
        count_n         = CW'(t - N_T);
        flush_pending_n = flush_req && (t != N_T);
      end else if (flush_req && t != '0) begin
        valid_n  = 1'b1;
        vector_n = wide[N-1:0];
        fill_n   = LW'(t);
        acc_n    = '0;
        count_n  = '0;
      end else if (accept) begin
        acc_n   = wide[N-1:0];
        count_n = CW'(t);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc           <= '0;
      count         <= '0;
      flush_pending <= 1'b0;
      valid_out     <= 1'b0;
      vector_out    <= '0;
      fill_out      <= '0;
    end else begin
      acc           <= acc_n;
      count         <= count_n;
      flush_pending <= flush_pending_n;
      valid_out     <= valid_n;
      vector_out    <= vector_n;
      fill_out      <= fill_n;
    end
  end

endmodule

// File: tb/tb_multi_length_packer.sv
// Directed bench for multi_length_packer: full-length packing, word splitting,
// flush with carry, backpressure, configuration filtering and mid-word reset.
module tb_multi_length_packer;

  localparam int N  = 8;
  localparam int DW = 32;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tracing;
  logic       valid_in;
  logic       ready_out;
  logic [1:0] eof_in;
  logic [1:0] bof_in;
  logic [1:0] chain_id;
  logic       flush_in;
  logic [7:0] config_id;
  logic [7:0] config_data;
  vec_t       vector_in;
  vec_t       vector_out;
  logic [3:0] fill_out;
  logic       valid_out;
  logic       ready_in;

  int   tests  = 0;
  int   failed = 0;
  vec_t exp;

  multi_length_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tracing    (tracing),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .eof_in     (eof_in),
    .bof_in     (bof_in),
    .chainId_in (chain_id),
    .flush_in   (flush_in),
    .configId   (config_id),
    .configData (config_data),
    .vector_in  (vector_in),
    .vector_out (vector_out),
    .fill_out   (fill_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] el(input logic [7:0] tag, input int i);
    return {tag, 16'h0000, 8'(i)};
  endfunction

  // Lanes beyond the vector length carry junk that must never reach the output.
  function automatic vec_t mkvec(input logic [7:0] tag, input int len);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = (i < len) ? el(tag, i) : 32'hDEAD_BEEF;
    return v;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag, input logic ev, input logic [3:0] ef, input vec_t evec);
    tests++;
    assert (valid_out === ev) else begin
      failed++;
      $error("FAIL %s.valid observed=%0b expected=%0b", tag, valid_out, ev);
    end
    tests++;
    assert (fill_out === ef) else begin
      failed++;
      $error("FAIL %s.fill observed=%0d expected=%0d", tag, fill_out, ef);
    end
    tests++;
    assert (vector_out === evec) else begin
      failed++;
      $error("FAIL %s.vector observed=%0h expected=%0h", tag, vector_out, evec);
    end
  endtask

  task automatic put(input logic [1:0] ch, input vec_t d, input logic fl, input logic [1:0] eof);
    valid_in  = 1'b1;
    chain_id  = ch;
    vector_in = d;
    flush_in  = fl;
    eof_in    = eof;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    flush_in = 1'b0;
  endtask

  // Byte i of the stream sits in bits [8i+7:8i]; called and returns at a negedge.
  task automatic configure(input logic [63:0] bytes);
    tracing   = 1'b0;
    config_id = 8'h00;
    #1 check_bit("cfg_ready_low", ready_out, 1'b0);
    for (int i = 0; i < 8; i++) begin
      config_data = bytes[i*8 +: 8];
      @(negedge clk);
    end
    tracing     = 1'b1;
    config_id   = 8'hFF;
    config_data = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0; tracing = 1'b1; valid_in = 1'b0; ready_in = 1'b1; flush_in = 1'b0;
    eof_in = 2'b00; bof_in = 2'b00; chain_id = 2'd0; config_id = 8'hFF; config_data = 8'h00;
    vector_in = '0;
    repeat (2) @(negedge clk);
    check_out("reset", 1'b0, 4'd0, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("ready_after_reset", ready_out, 1'b1);

    // Full-length vectors: one word per accept, one cycle later.
    put(2'd0, mkvec(8'h11, 8), 1'b0, 2'b00);
    @(negedge clk); check_out("l8_w1", 1'b1, 4'd8, mkvec(8'h11, 8));
    put(2'd0, mkvec(8'h12, 8), 1'b0, 2'b00);
    @(negedge clk); check_out("l8_w2", 1'b1, 4'd8, mkvec(8'h12, 8));
    put(2'd0, mkvec(8'h13, 8), 1'b0, 2'b00);
    @(negedge clk); check_out("l8_w3", 1'b1, 4'd8, mkvec(8'h13, 8));
    idle();
    @(negedge clk); check_bit("l8_drain", valid_out, 1'b0);

    // Lengths: chain0=8, chain1=3, chain2=5, chain3=8; no conditions.
    configure(64'h08050308_00000000);

    // Three 3-lane vectors: word of A0..A2,B0..B2,C0,C1 and C2 left behind.
    put(2'd1, mkvec(8'hA0, 3), 1'b0, 2'b00);
    @(negedge clk); check_bit("l3_no_out_a", valid_out, 1'b0);
    put(2'd1, mkvec(8'hB0, 3), 1'b0, 2'b00);
    @(negedge clk); check_bit("l3_no_out_b", valid_out, 1'b0);
    put(2'd1, mkvec(8'hC0, 3), 1'b0, 2'b00);
    @(negedge clk);
    idle();
    exp = {el(8'hC0, 1), el(8'hC0, 0), el(8'hB0, 2), el(8'hB0, 1),
           el(8'hB0, 0), el(8'hA0, 2), el(8'hA0, 1), el(8'hA0, 0)};
    check_out("l3_word", 1'b1, 4'd8, exp);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    exp = '0;
    exp[0] = el(8'hC0, 2);
    check_out("l3_flush_rem", 1'b1, 4'd1, exp);

    // count=6, then a 5-lane vector together with flush: full word, then 3 lanes.
    put(2'd1, mkvec(8'hD0, 3), 1'b0, 2'b00);
    @(negedge clk); check_bit("fl_no_out_d", valid_out, 1'b0);
    put(2'd1, mkvec(8'hE0, 3), 1'b0, 2'b00);
    @(negedge clk);
    put(2'd2, mkvec(8'hF0, 5), 1'b1, 2'b00);
    @(negedge clk);
    idle();
    #1 check_bit("fl_pending_ready", ready_out, 1'b0);
    exp = {el(8'hF0, 1), el(8'hF0, 0), el(8'hE0, 2), el(8'hE0, 1),
           el(8'hE0, 0), el(8'hD0, 2), el(8'hD0, 1), el(8'hD0, 0)};
    check_out("fl_full", 1'b1, 4'd8, exp);
    @(negedge clk);
    exp = '0;
    exp[0] = el(8'hF0, 2);
    exp[1] = el(8'hF0, 3);
    exp[2] = el(8'hF0, 4);
    check_out("fl_partial", 1'b1, 4'd3, exp);
    check_bit("fl_ready_back", ready_out, 1'b1);

    // Backpressure: a pending word must hold while ready_in is low.
    put(2'd0, mkvec(8'h41, 8), 1'b0, 2'b00);
    @(negedge clk);
    check_out("bp_first", 1'b1, 4'd8, mkvec(8'h41, 8));
    ready_in = 1'b0;
    put(2'd0, mkvec(8'h42, 8), 1'b0, 2'b00);
    #1 check_bit("bp_ready_low", ready_out, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_out($sformatf("bp_hold%0d", i), 1'b1, 4'd8, mkvec(8'h41, 8));
      check_bit($sformatf("bp_ready%0d", i), ready_out, 1'b0);
    end
    ready_in = 1'b1;
    @(negedge clk);
    idle();
    check_out("bp_second", 1'b1, 4'd8, mkvec(8'h42, 8));
    @(negedge clk); check_bit("bp_drain", valid_out, 1'b0);

    // Reset mid-word: count=5 and a word pending, then only post-reset data.
    put(2'd2, mkvec(8'h61, 5), 1'b0, 2'b00);
    @(negedge clk);
    put(2'd0, mkvec(8'h62, 8), 1'b0, 2'b00);
    @(negedge clk);
    idle();
    exp = {el(8'h62, 2), el(8'h62, 1), el(8'h62, 0), el(8'h61, 4),
           el(8'h61, 3), el(8'h61, 2), el(8'h61, 1), el(8'h61, 0)};
    check_out("rst_pre_word", 1'b1, 4'd8, exp);
    #1 rst_n = 1'b0;
    #1 check_out("rst_mid", 1'b0, 4'd0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    put(2'd0, mkvec(8'h63, 8), 1'b0, 2'b00);
    @(negedge clk);
    idle();
    check_out("rst_post_word", 1'b1, 4'd8, mkvec(8'h63, 8));

    // Chain 0: length 2, packs only when eof_in[0]=1.
    configure(64'h08080802_00000001);
    put(2'd0, mkvec(8'h71, 2), 1'b0, 2'b01);
    @(negedge clk);
    put(2'd0, mkvec(8'h72, 2), 1'b0, 2'b00);
    #1 check_bit("cond_drop_ready", ready_out, 1'b1);
    @(negedge clk);
    put(2'd0, mkvec(8'h73, 2), 1'b0, 2'b01);
    @(negedge clk);
    put(2'd0, mkvec(8'h74, 2), 1'b0, 2'b01);
    @(negedge clk);
    check_bit("cond_no_out", valid_out, 1'b0);
    put(2'd0, mkvec(8'h75, 2), 1'b0, 2'b01);
    @(negedge clk);
    idle();
    exp = {el(8'h75, 1), el(8'h75, 0), el(8'h74, 1), el(8'h74, 0),
           el(8'h73, 1), el(8'h73, 0), el(8'h71, 1), el(8'h71, 0)};
    check_out("cond_word", 1'b1, 4'd8, exp);
    @(negedge clk); check_bit("cond_drain", valid_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
